// File: rtl/microsequencer.sv
// Next-state address generator for the microprogrammed control store. The optional
// return stack is built only when MSEQ_STACK_EN is defined.
module microsequencer #(
  parameter logic [7:0] FETCH_ADDR = 8'd1,
  parameter logic [7:0] TRAP_ADDR  = 8'd0,
  parameter int         STK_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [2:0] n,
  input  logic       inv,
  input  logic       mi,
  input  logic [2:0] s,
  input  logic [7:0] cr,
  input  logic [7:0] dec_addr,
  input  logic       dec_valid,
  input  logic       moc,
  input  logic       cond_ok,
  input  logic       z,
  input  logic       nf,
  input  logic       c,
  input  logic       v,
  input  logic       lsm_done,
  output logic [7:0] state,
  output logic       stk_err
);

  logic [7:0] state_reg, state_next;
  logic [7:0] inc;
  logic [7:0] dec_target;
  logic [7:0] cond_vec;
  logic       t;
  logic       advance;
  logic [7:0] call_tgt;
  logic [7:0] ret_tgt;

  assign cond_vec   = {1'b1, lsm_done, v, c, nf, z, cond_ok, moc};
  assign t          = cond_vec[s] ^ inv;
  assign inc        = state_reg + 8'd1;
  assign dec_target = dec_valid ? dec_addr : TRAP_ADDR;
  // A sequencing decision is taken only when not stalled and not waiting on memory.
  assign advance    = !hold && !(mi && !moc);

`ifdef MSEQ_STACK_EN
  localparam int SPW = $clog2(STK_DEPTH);
  localparam logic [SPW:0] FULL_CNT = (SPW+1)'(STK_DEPTH);

  logic [SPW:0]   sp_reg, sp_next;
  logic [SPW:0]   sp_dec;
  logic [SPW-1:0] wr_idx, rd_idx;
  logic           err_reg, err_next;
  logic           stk_full, stk_empty;
  logic           push_en;
  logic [7:0]     stk_q [STK_DEPTH];

  assign stk_full  = (sp_reg == FULL_CNT);
  assign stk_empty = (sp_reg == '0);
  assign sp_dec    = sp_reg - 1'b1;
  assign wr_idx    = sp_reg[SPW-1:0];
  assign rd_idx    = sp_dec[SPW-1:0];

  // One register per stack slot; a push writes the return address at the current SP.
  generate
    for (genvar gi = 0; gi < STK_DEPTH; gi++) begin : g_stk
      logic [7:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push_en && (wr_idx == SPW'(gi))) begin
          entry_reg <= inc;
        end
      end
      assign stk_q[gi] = entry_reg;
    end
  endgenerate

  assign call_tgt = stk_full  ? TRAP_ADDR : cr;
  assign ret_tgt  = stk_empty ? TRAP_ADDR : stk_q[rd_idx];

  always_comb begin
    sp_next  = sp_reg;
    err_next = err_reg;
    push_en  = 1'b0;
    if (advance && (n == 3'b110)) begin
      if (stk_full) begin
        err_next = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_next = sp_reg + 1'b1;
      end
    end else if (advance && (n == 3'b111)) begin
      if (stk_empty) begin
        err_next = 1'b1;
      end else begin
        sp_next = sp_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      sp_reg  <= sp_next;
      err_reg <= err_next;
    end
  end

  assign stk_err = err_reg;
`else
  // Without a stack, call degenerates to a jump and return to a fresh fetch.
  assign call_tgt = cr;
  assign ret_tgt  = FETCH_ADDR;
  assign stk_err  = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    if (advance) begin
      case (n)
        3'b000:  state_next = dec_target;
        3'b001:  state_next = FETCH_ADDR;
        3'b010:  state_next = cr;
        3'b011:  state_next = inc;
        3'b100:  state_next = t ? cr : inc;
        3'b101:  state_next = t ? cr : dec_target;
        3'b110:  state_next = call_tgt;
        default: state_next = ret_tgt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= TRAP_ADDR;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed vector table, hand-written stack
// sequences and randomized traffic against a queue-based reference model.
module tb_microsequencer;

  localparam logic [7:0] FETCH = 8'd1;
  localparam logic [7:0] TRAP  = 8'd0;
  localparam int         DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, hold, inv, mi, dec_valid, moc, cond_ok, z, nf, c, v, lsm_done;
  logic [2:0] n, s;
  logic [7:0] cr, dec_addr;
  logic [7:0] state;
  logic       stk_err;

  int n_cmp = 0;
  int n_bad = 0;

  microsequencer #(.FETCH_ADDR(FETCH), .TRAP_ADDR(TRAP), .STK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .hold(hold), .n(n), .inv(inv), .mi(mi), .s(s), .cr(cr),
    .dec_addr(dec_addr), .dec_valid(dec_valid), .moc(moc), .cond_ok(cond_ok),
    .z(z), .nf(nf), .c(c), .v(v), .lsm_done(lsm_done), .state(state), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       hld;
    logic [2:0] nn;
    logic       iv;
    logic       m;
    logic [2:0] ss;
    logic [7:0] crv;
    logic [7:0] da;
    logic       dv;
    logic       mc;
    logic       cok;
    logic [3:0] zncv;
    logic       lsm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [7:0] m_state;
  logic       m_err;
  logic [7:0] m_stk[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle();
    reset = 0; hold = 0; n = 3'b011; inv = 0; mi = 0; s = 0; cr = 0; dec_addr = 0;
    dec_valid = 0; moc = 0; cond_ok = 0; z = 0; nf = 0; c = 0; v = 0; lsm_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] nn, input logic [7:0] crv);
    idle();
    n = nn; cr = crv;
  endtask

  task automatic model_step();
    logic cond;
    logic [7:0] inc, dect;
    inc  = m_state + 8'd1;
    dect = dec_valid ? dec_addr : TRAP;
    case (s)
      3'd0: cond = moc;
      3'd1: cond = cond_ok;
      3'd2: cond = z;
      3'd3: cond = nf;
      3'd4: cond = c;
      3'd5: cond = v;
      3'd6: cond = lsm_done;
      default: cond = 1'b1;
    endcase
    cond = cond ^ inv;
    if (reset) begin
      m_state = TRAP; m_err = 0; m_stk.delete();
    end else if (hold || (mi && !moc)) begin
      m_state = m_state;
    end else begin
      case (n)
        3'd0: m_state = dect;
        3'd1: m_state = FETCH;
        3'd2: m_state = cr;
        3'd3: m_state = inc;
        3'd4: m_state = cond ? cr : inc;
        3'd5: m_state = cond ? cr : dect;
`ifdef MSEQ_STACK_EN
        3'd6: begin
          if (m_stk.size() >= DEPTH) begin
            m_state = TRAP; m_err = 1;
          end else begin
            m_stk.push_back(inc); m_state = cr;
          end
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_state = TRAP; m_err = 1;
          end else begin
            m_state = m_stk.pop_back();
          end
        end
`else
        3'd6: m_state = cr;
        default: m_state = FETCH;
`endif
      endcase
    end
  endtask

  initial begin
    idle();
    reset = 1;

    // rst hld n   iv mi s   cr     da     dv mc cok zncv  lsm exp
    vecs.push_back('{1, 0, 3'd3, 0, 0, 3'd0, 8'd0,  8'd0,  0, 0, 0, 4'h0, 0, 8'd0});
    vecs.push_back('{1, 0, 3'd3, 0, 0, 3'd0, 8'd0,  8'd0,  0, 0, 0, 4'h0, 0, 8'd0});
    vecs.push_back('{0, 0, 3'd3, 0, 0, 3'd0, 8'd0,  8'd0,  0, 0, 0, 4'h0, 0, 8'd1});
    vecs.push_back('{0, 0, 3'd3, 0, 0, 3'd0, 8'd0,  8'd0,  0, 0, 0, 4'h0, 0, 8'd2});
    vecs.push_back('{0, 0, 3'd3, 0, 0, 3'd0, 8'd0,  8'd0,  0, 0, 0, 4'h0, 0, 8'd3});
    vecs.push_back('{0, 0, 3'd2, 0, 0, 3'd0, 8'd5,  8'd0,  0, 0, 0, 4'h0, 0, 8'd5});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{0, 0, 3'd2, 0, 1, 3'd0, 8'd30, 8'd0, 0, 0, 0, 4'h0, 0, 8'd5});
    vecs.push_back('{0, 0, 3'd2, 0, 1, 3'd0, 8'd30, 8'd0,  0, 1, 0, 4'h0, 0, 8'd30});
    vecs.push_back('{0, 0, 3'd2, 0, 0, 3'd0, 8'd10, 8'd0,  0, 0, 0, 4'h0, 0, 8'd10});
    vecs.push_back('{0, 0, 3'd4, 1, 0, 3'd2, 8'd40, 8'd0,  0, 0, 0, 4'h8, 0, 8'd11});
    vecs.push_back('{0, 0, 3'd2, 0, 0, 3'd0, 8'd10, 8'd0,  0, 0, 0, 4'h0, 0, 8'd10});
    vecs.push_back('{0, 0, 3'd4, 1, 0, 3'd2, 8'd40, 8'd0,  0, 0, 0, 4'h0, 0, 8'd40});
    vecs.push_back('{0, 0, 3'd5, 0, 0, 3'd1, 8'd77, 8'h55, 0, 0, 0, 4'h0, 0, 8'd0});
    vecs.push_back('{0, 0, 3'd2, 0, 0, 3'd0, 8'hFF, 8'd0,  0, 0, 0, 4'h0, 0, 8'hFF});
    vecs.push_back('{0, 0, 3'd3, 0, 0, 3'd0, 8'd0,  8'd0,  0, 0, 0, 4'h0, 0, 8'h00});
    vecs.push_back('{0, 0, 3'd0, 0, 0, 3'd0, 8'd0,  8'h9A, 1, 0, 0, 4'h0, 0, 8'h9A});
    vecs.push_back('{0, 1, 3'd6, 0, 0, 3'd0, 8'd50, 8'd0,  0, 0, 0, 4'h0, 0, 8'h9A});
    vecs.push_back('{0, 0, 3'd1, 0, 0, 3'd0, 8'd0,  8'd0,  0, 0, 0, 4'h0, 0, 8'd1});
    vecs.push_back('{0, 0, 3'd5, 0, 0, 3'd7, 8'd33, 8'd0,  0, 0, 0, 4'h0, 0, 8'd33});
    vecs.push_back('{0, 0, 3'd4, 0, 0, 3'd6, 8'd99, 8'd0,  0, 0, 0, 4'h0, 0, 8'd34});
    vecs.push_back('{0, 0, 3'd4, 0, 0, 3'd0, 8'd12, 8'd0,  0, 1, 0, 4'h0, 0, 8'd12});
    vecs.push_back('{0, 0, 3'd4, 0, 0, 3'd3, 8'd70, 8'd0,  0, 0, 0, 4'h4, 0, 8'd70});
    vecs.push_back('{0, 0, 3'd4, 0, 0, 3'd4, 8'd90, 8'd0,  0, 0, 0, 4'hD, 0, 8'd71});
    vecs.push_back('{0, 0, 3'd4, 0, 0, 3'd5, 8'd20, 8'd0,  0, 0, 0, 4'h1, 0, 8'd20});
    vecs.push_back('{0, 0, 3'd5, 1, 0, 3'd1, 8'd60, 8'h44, 1, 0, 1, 4'h0, 0, 8'h44});

    foreach (vecs[i]) begin
      reset = vecs[i].rst; hold = vecs[i].hld; n = vecs[i].nn; inv = vecs[i].iv;
      mi = vecs[i].m; s = vecs[i].ss; cr = vecs[i].crv; dec_addr = vecs[i].da;
      dec_valid = vecs[i].dv; moc = vecs[i].mc; cond_ok = vecs[i].cok;
      {z, nf, c, v} = vecs[i].zncv; lsm_done = vecs[i].lsm;
      tick();
      chk($sformatf("vec%0d state", i), state, vecs[i].exp);
      chk($sformatf("vec%0d stk_err", i), {7'd0, stk_err}, 8'd0);
    end

    // Stack sequences
    idle(); reset = 1; tick();
`ifdef MSEQ_STACK_EN
    drive(3'd2, 8'd20); tick(); chk("goto20", state, 8'd20);
    drive(3'd6, 8'd50); tick(); chk("call50", state, 8'd50);
    drive(3'd3, 8'd0);  tick(); chk("body51", state, 8'd51);
    drive(3'd7, 8'd0);  tick(); chk("ret21", state, 8'd21);
    chk("ret_err", {7'd0, stk_err}, 8'd0);

    for (int i = 0; i < 4; i++) begin
      drive(3'd6, 8'd60 + 8'(i)); tick(); chk($sformatf("nest%0d", i), state, 8'd60 + 8'(i));
    end
    drive(3'd6, 8'd70); tick(); chk("overflow state", state, TRAP);
    chk("overflow err", {7'd0, stk_err}, 8'd1);
    drive(3'd3, 8'd0); tick(); tick();
    chk("err sticky", {7'd0, stk_err}, 8'd1);
    drive(3'd7, 8'd0); tick(); chk("ret after ovf", state, 8'd64);
    idle(); reset = 1; tick(); chk("err cleared", {7'd0, stk_err}, 8'd0);

    drive(3'd6, 8'd80); tick(); drive(3'd6, 8'd90); tick();
    chk("depth2", state, 8'd90);
    drive(3'd6, 8'd99); reset = 1; tick(); chk("reset midcall", state, TRAP);
    drive(3'd7, 8'd0); tick(); chk("underflow state", state, TRAP);
    chk("underflow err", {7'd0, stk_err}, 8'd1);

    idle(); reset = 1; tick();
    drive(3'd6, 8'd50); hold = 1; tick(); tick();
    chk("held call", state, TRAP);
    hold = 0; tick(); chk("released call", state, 8'd50);
    drive(3'd7, 8'd0); tick(); chk("single push ret", state, 8'd1);
    drive(3'd7, 8'd0); tick(); chk("sp unchanged by hold", {7'd0, stk_err}, 8'd1);
`else
    drive(3'd6, 8'd50); tick(); chk("call as jump", state, 8'd50);
    drive(3'd7, 8'd0);  tick(); chk("ret as fetch", state, FETCH);
    drive(3'd7, 8'd0);  tick(); chk("no stk_err", {7'd0, stk_err}, 8'd0);
`endif

    // Randomized traffic against the reference model
    idle(); reset = 1;
    model_step(); tick();
    chk("rand reset", state, m_state);
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(63) == 0);
      hold      = ($urandom_range(7) == 0);
      mi        = ($urandom_range(3) == 0);
      moc       = $urandom_range(1);
      n         = 3'($urandom_range(7));
      s         = 3'($urandom_range(7));
      inv       = $urandom_range(1);
      cr        = 8'($urandom_range(255));
      dec_addr  = 8'($urandom_range(255));
      dec_valid = $urandom_range(1);
      cond_ok   = $urandom_range(1);
      {z, nf, c, v} = 4'($urandom_range(15));
      lsm_done  = $urandom_range(1);
      model_step();
      tick();
      if ((state !== m_state) || (stk_err !== m_err)) begin
        chk($sformatf("rand%0d state", i), state, m_state);
        chk($sformatf("rand%0d err", i), {7'd0, stk_err}, {7'd0, m_err});
      end else begin
        n_cmp += 2;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
